aes_decrypt_iter: RTL

//  Iterative AES inverse cipher: one round per clock over a single 128-bit state

---
 rtl/aes_decrypt_iter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock over a single 128-bit state
// register, with a cached key and valid/ready handshakes on both sides.
module aes_decrypt_iter #(
   parameter int N  = 128,
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   key_in,
   input  logic           key_load,
   output logic           key_valid,
   input  logic [127:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [127:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy
);

   localparam int CW = $clog2(Nr + 1);
   localparam int NW = 4 * (Nr + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    fsm;
   logic [CW-1:0] cnt;
   logic [127:0]  state_reg;
   logic [N-1:0]  key_reg;
   logic [127:0]  rk [0:Nr];
   logic [127:0]  ark;
   logic [127:0]  mid;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Field inverse as a^254 (maps 0 to 0, which is what the S-box needs)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = ginv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
             {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] y;
      y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(y);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Forward key expansion, then round keys listed in decryption order:
   // rk[0] is the last encryption round key, rk[Nr] is the cipher key itself.
   always_comb begin
      logic [31:0] w [0:NW-1];
      logic [31:0] t;
      logic [7:0]  rc;
      w  = '{default: '0};
      t  = '0;
      rc = 8'h01;
      for (int i = 0; i < Nk; i++) begin
         w[i] = key_reg[N-1-32*i -: 32];
      end
      for (int i = Nk; i < NW; i++) begin
         t = w[i-1];
         if (i % Nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end else if (Nk > 6 && i % Nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-Nk] ^ t;
      end
      for (int r = 0; r <= Nr; r++) begin
         rk[r] = {w[4*(Nr-r)], w[4*(Nr-r)+1], w[4*(Nr-r)+2], w[4*(Nr-r)+3]};
      end
   end

   // InvShiftRows + InvSubBytes + AddRoundKey; the last round stops here
   always_comb begin
      ark = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            ark[127-8*(r+4*c) -: 8] = inv_sbox(state_reg[127-8*(r+4*((c-r+4)%4)) -: 8]);
         end
      end
      ark = ark ^ rk[cnt];
   end

   always_comb begin
      mid = inv_mix_columns(ark);
   end

   // Round sequencer; key loads are only taken while no block is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         cnt       <= '0;
         state_reg <= '0;
         key_reg   <= '0;
         key_valid <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (key_load) begin
                  key_reg   <= key_in;
                  key_valid <= 1'b1;
               end else if (in_valid && in_ready) begin
                  state_reg <= in_data ^ rk[0];
                  cnt       <= CW'(1);
                  fsm       <= ROUND;
               end
            end
            ROUND: begin
               if (cnt == CW'(Nr)) begin
                  state_reg <= ark;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  state_reg <= mid;
                  cnt       <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  cnt       <= '0;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign in_ready = (fsm == IDLE) && key_valid && !key_load;
   assign busy     = (fsm != IDLE);
   assign out_data = state_reg;

endmodule
